// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back stage that merges ALU results (A) and buffered LSU/MDU results (B).
// Define WB_FWD_EN to add the fwd_addr/fwd_hit/fwd_data forwarding port.
module wb_arbiter #(
  parameter int WIDTH        = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [WIDTH-1:0]        a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [WIDTH-1:0]        b_data,
  output logic                    we,
  output logic [ADDR_WIDTH-1:0]   addrw,
  output logic [WIDTH-1:0]        dinw,
`ifdef WB_FWD_EN
  input  logic [ADDR_WIDTH-1:0]   fwd_addr,
  output logic                    fwd_hit,
  output logic [WIDTH-1:0]        fwd_data,
`endif
  output logic [$clog2(DEPTH):0]  count,
  output logic                    busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
  logic [WIDTH-1:0]      r_mem_data [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [SW-1:0]         r_starve;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addrw;
  logic [WIDTH-1:0]      r_dinw;

  logic                  w_busy;
  logic                  w_force;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_take_a;
  logic                  w_issue;
  logic [ADDR_WIDTH-1:0] w_iss_addr;
  logic [WIDTH-1:0]      w_iss_data;

  assign w_busy   = (r_count != '0);
  assign w_force  = w_busy && (r_starve == SLIM);
  assign w_push   = b_valid && (r_count != FULL);
  assign w_pop    = w_force || (!a_valid && w_busy);
  assign w_take_a = !w_force && a_valid;
  assign w_issue  = w_pop || w_take_a;

  // Issue mux: FIFO head when popping, otherwise the A-side result.
  always_comb begin
    w_iss_addr = a_addr;
    w_iss_data = a_data;
    if (w_pop) begin
      w_iss_addr = r_mem_addr[r_rd_ptr];
      w_iss_data = r_mem_data[r_rd_ptr];
    end
  end

  assign a_ready = !w_force;
  assign b_ready = (r_count != FULL);
  assign busy    = w_busy;
  assign count   = r_count;
  assign we      = r_we;
  assign addrw   = r_addrw;
  assign dinw    = r_dinw;

`ifdef WB_FWD_EN
  assign fwd_hit  = r_we && (r_addrw == fwd_addr) && (fwd_addr != '0);
  assign fwd_data = r_dinw;
`endif

  // FIFO storage; contents are don't-care until a push lands.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= b_addr;
      r_mem_data[r_wr_ptr] <= b_data;
    end
  end

  // FIFO pointers and occupancy; a full FIFO never pushes, even on a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Starvation counter: how long the FIFO head has waited behind A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (!w_busy || w_pop) begin
      r_starve <= '0;
    end else if (r_starve != SLIM) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  // Registered write port; x0 issues are consumed without asserting we.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addrw <= '0;
      r_dinw  <= '0;
    end else begin
      r_we <= w_issue && (w_iss_addr != '0);
      if (w_issue) begin
        r_addrw <= w_iss_addr;
        r_dinw  <= w_iss_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter
// against a queue-based reference model.
module tb_wb_arbiter;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int D  = 4;
  localparam int SL = 3;

  logic          clk;
  logic          rst;
  logic          a_valid, a_ready;
  logic [AW-1:0] a_addr;
  logic [W-1:0]  a_data;
  logic          b_valid, b_ready;
  logic [AW-1:0] b_addr;
  logic [W-1:0]  b_data;
  logic          we;
  logic [AW-1:0] addrw;
  logic [W-1:0]  dinw;
  logic [2:0]    count;
  logic          busy;
`ifdef WB_FWD_EN
  logic [AW-1:0] fwd_addr;
  logic          fwd_hit;
  logic [W-1:0]  fwd_data;
`endif

  int total = 0;
  int bad   = 0;

  logic [AW+W-1:0] m_q[$];
  int              m_st;
  logic            m_we;
  logic [AW-1:0]   m_addrw;
  logic [W-1:0]    m_dinw;
  logic            acc;

  wb_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(D), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .we(we), .addrw(addrw), .dinw(dinw),
`ifdef WB_FWD_EN
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
    .count(count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, compare against the model, advance it.
  task automatic cycle(input logic av, input logic [AW-1:0] aa,
                       input logic [W-1:0] ad, input logic bv,
                       input logic [AW-1:0] ba, input logic [W-1:0] bd,
                       output logic accepted);
    bit m_busy, m_frc, m_pop, m_take;
    logic [AW+W-1:0] e;
    logic [AW-1:0] ia;
    logic [W-1:0] id;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    m_busy = (m_q.size() != 0);
    m_frc  = m_busy && (m_st == SL);
    check("a_ready", a_ready, !m_frc);
    check("b_ready", b_ready, m_q.size() < D);
    check("we", we, m_we);
    check("addrw", addrw, m_addrw);
    check("dinw", dinw, m_dinw);
    check("count", count, m_q.size());
    check("busy", busy, m_busy);
    m_pop    = m_frc || (!av && m_busy);
    m_take   = !m_frc && av;
    accepted = bv && (m_q.size() < D);
    ia = aa;
    id = ad;
    if (m_pop) begin
      e  = m_q.pop_front();
      ia = e[AW+W-1:W];
      id = e[W-1:0];
    end
    if (!m_busy || m_pop) m_st = 0;
    else if (m_st < SL)   m_st = m_st + 1;
    m_we = (m_pop || m_take) && (ia != 0);
    if (m_pop || m_take) begin
      m_addrw = ia;
      m_dinw  = id;
    end
    if (accepted) m_q.push_back({ba, bd});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic x;
    repeat (n) cycle(1'b0, '0, '0, 1'b0, '0, '0, x);
  endtask

  // Assert reset between edges; state must clear before any edge.
  task automatic do_reset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_count", count, 0);
    check("rst_we", we, 0);
    check("rst_busy", busy, 0);
    check("rst_b_ready", b_ready, 1);
    check("rst_a_ready", a_ready, 1);
    check("rst_addrw", addrw, 0);
    check("rst_dinw", dinw, 0);
    m_q.delete();
    m_st = 0;
    m_we = 1'b0;
    m_addrw = '0;
    m_dinw = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int j;
    rst = 1'b1;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
`ifdef WB_FWD_EN
    fwd_addr = '0;
`endif
    @(negedge clk);
    do_reset();

    // A only
    cycle(1'b1, 5, 32'h0000_1234, 1'b0, '0, '0, acc);
    check("t1_we", we, 1);
    check("t1_addrw", addrw, 5);
    check("t1_dinw", dinw, 32'h0000_1234);
    idle(1);
    check("t1_we_low", we, 0);

    // x0 drop
    cycle(1'b1, 0, 32'hFFFF_FFFF, 1'b0, '0, '0, acc);
    check("t2_we", we, 0);
    idle(1);

    // Full FIFO with A held
    j = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        check("t3_count4", count, 4);
        check("t3_b_ready0", b_ready, 0);
        check("t3_force", a_ready, 0);
      end
      cycle(1'b1, 1, i, j < 5, AW'(10 + j), 32'(100 + j), acc);
      if (i == 5) check("t3_5th_acc", acc, 1);
      if (acc) j++;
    end
    check("t3_pushes", j, 5);
    idle(D + 2);
    check("t3_drained", count, 0);

    // Starvation
    cycle(1'b1, 1, 32'h1, 1'b1, 9, 32'hAB, acc);
    for (int i = 1; i < 4; i++) begin
      check("t4_a_ready_wait", a_ready, 1);
      cycle(1'b1, 1, 32'h1, 1'b0, '0, '0, acc);
    end
    check("t4_a_ready_forced", a_ready, 0);
    cycle(1'b1, 1, 32'h1, 1'b0, '0, '0, acc);
    check("t4_we", we, 1);
    check("t4_addrw", addrw, 9);
    check("t4_dinw", dinw, 32'hAB);
    check("t4_a_ready_back", a_ready, 1);
    idle(4);

    // Reset mid-operation
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 1, 32'h55, 1'b1, AW'(20 + k), 32'(k), acc);
    check("t5_count3", count, 3);
    check("t5_we1", we, 1);
    do_reset();
    idle(3);
    check("t5_no_stale", we, 0);

`ifdef WB_FWD_EN
    cycle(1'b1, 7, 32'hDEAD_BEEF, 1'b0, '0, '0, acc);
    fwd_addr = 7;
    #1;
    check("t6_hit", fwd_hit, 1);
    check("t6_data", fwd_data, 32'hDEAD_BEEF);
    fwd_addr = 0;
    #1;
    check("t6_x0", fwd_hit, 0);
    fwd_addr = 8;
    #1;
    check("t6_miss", fwd_hit, 0);
    fwd_addr = 0;
    idle(1);
`endif

    // Randomized traffic with a reset in the middle
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      cycle($urandom_range(0, 99) < 55, AW'($urandom_range(0, 31)),
            $urandom, $urandom_range(0, 99) < 60,
            AW'($urandom_range(0, 31)), $urandom, acc);
    end
    idle(D + SL + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
